execute_pipe: RTL and testbench

// - Parametrised, registered execute stage for the pipelined LEGv8 core; sits between ID/EX and MEM.
// - Computes ALU result, store data, zero flag and branch target; registers them into the EX/MEM boundary.
// - Adds an optional iterative multiplier (MUL) that stalls upstream through a valid/ready handshake.
// - Supports a synchronous flush for branch mispredicts.

---
 rtl/alu_pkg.sv | 17 +
 rtl/adder.sv | 12 +
 rtl/alu.sv | 27 ++
 rtl/execute_pipe_mul_iter.sv | 64 ++++++
 rtl/mux2.sv | 13 +
 rtl/execute_pipe.sv | 122 ++++++++++++
 tb/tb_execute_pipe.sv | 251 +++++++++++++++++++++++++
 7 files changed

// File: rtl/alu_pkg.sv
// Shared ALU function codes and execute-stage state type for the LEGv8 core.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_NOR   = 4'b1100;

    // Multiplier sequencing: IDLE accepts a start, BUSY runs one shift-add step per edge.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ex_state_t;

endpackage

// File: rtl/adder.sv
// N-bit wrapping adder cell.
module adder #(
    parameter int N = 64
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);

    assign y = a + b;

endmodule

// File: rtl/alu.sv
// Combinational ALU; unsupported function codes return 0.
module alu
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [3:0]   ctrl,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);

    // Function select; all arithmetic wraps mod 2^N.
    always_comb begin
        y = '0;
        case (ctrl)
            ALU_AND:   y = a & b;
            ALU_OR:    y = a | b;
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = a - b;
            ALU_PASSB: y = b;
            ALU_NOR:   y = ~(a | b);
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/execute_pipe_mul_iter.sv
// Iterative shift-add multiplier: one partial product per edge, N edges per op.
// The product is presented combinationally on the final step so the caller
// can register it at the same edge that the step completes.
module mul_iter
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] product
);

    localparam int CW = $clog2(N + 1);

    ex_state_t     state;
    logic [N-1:0]  acc;
    logic [N-1:0]  a_r;
    logic [N-1:0]  b_r;
    logic [CW-1:0] cnt;
    logic [N-1:0]  acc_next;

    assign acc_next = acc + (b_r[0] ? a_r : '0);
    assign busy     = (state == BUSY);
    assign done     = busy && (cnt == CW'(1));
    assign product  = acc_next;

    // Sequencer: load on start, then shift-add until the counter reaches its last step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            cnt   <= '0;
        end else if (clear) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                acc   <= '0;
                a_r   <= a;
                b_r   <= b;
                cnt   <= CW'(N);
                state <= BUSY;
            end
        end else begin
            acc <= acc_next;
            a_r <= a_r << 1;
            b_r <= b_r >> 1;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: rtl/mux2.sv
// Two-input multiplexer cell.
module mux2 #(
    parameter int N = 64
) (
    input  logic         sel,
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    output logic [N-1:0] y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/execute_pipe.sv
// LEGv8 execute stage with registered EX/MEM outputs and optional iterative MUL.
// Handshake: an op transfers at a rising edge where in_valid && in_ready && !flush;
// in_ready is low only while a multiply is in progress, and upstream must hold its op.
module execute_pipe
    import alu_pkg::*;
#(
    parameter int N      = 64,
    parameter bit MUL_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         AluSrc,
    input  logic [3:0]   AluControl,
    input  logic         MulOp,
    input  logic [N-1:0] PC_E,
    input  logic [N-1:0] signImm_E,
    input  logic [N-1:0] readData1_E,
    input  logic [N-1:0] readData2_E,
    output logic         out_valid,
    output logic [N-1:0] aluResult_M,
    output logic [N-1:0] writeData_M,
    output logic [N-1:0] PCBranch_M,
    output logic         zero_M
);

    logic [N-1:0] src_b;
    logic [N-1:0] alu_y;
    logic [N-1:0] pc_branch;
    logic         accept;
    logic         is_mul;
    logic         mul_busy;
    logic         mul_done;
    logic [N-1:0] mul_product;
    logic [N-1:0] wd_hold;
    logic [N-1:0] pcb_hold;

    mux2 #(.N(N)) u_srcb (
        .sel (AluSrc),
        .d0  (readData2_E),
        .d1  (signImm_E),
        .y   (src_b)
    );

    alu #(.N(N)) u_alu (
        .ctrl (AluControl),
        .a    (readData1_E),
        .b    (src_b),
        .y    (alu_y)
    );

    adder #(.N(N)) u_branch (
        .a (PC_E),
        .b (signImm_E << 2),
        .y (pc_branch)
    );

    assign is_mul   = MUL_EN && MulOp;
    assign in_ready = !mul_busy;
    assign accept   = in_valid && in_ready && !flush;

    generate
        if (MUL_EN) begin : g_mul
            mul_iter #(.N(N)) u_mul (
                .clk     (clk),
                .reset   (reset),
                .clear   (flush),
                .start   (accept && is_mul),
                .a       (readData1_E),
                .b       (src_b),
                .busy    (mul_busy),
                .done    (mul_done),
                .product (mul_product)
            );
        end else begin : g_nomul
            assign mul_busy    = 1'b0;
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    // Side data of a multiply is parked here until its product is ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_hold  <= '0;
            pcb_hold <= '0;
        end else if (accept && is_mul) begin
            wd_hold  <= readData2_E;
            pcb_hold <= pc_branch;
        end
    end

    // EX/MEM register: flush wins, then MUL completion, then a fresh ALU op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            aluResult_M <= '0;
            writeData_M <= '0;
            PCBranch_M  <= '0;
            zero_M      <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (mul_done) begin
            out_valid   <= 1'b1;
            aluResult_M <= mul_product;
            writeData_M <= wd_hold;
            PCBranch_M  <= pcb_hold;
            zero_M      <= (mul_product == '0);
        end else if (accept && !is_mul) begin
            out_valid   <= 1'b1;
            aluResult_M <= alu_y;
            writeData_M <= readData2_E;
            PCBranch_M  <= pc_branch;
            zero_M      <= (alu_y == '0);
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_execute_pipe.sv
// Self-checking bench for execute_pipe: directed spec scenarios plus random ALU/MUL ops.
module tb_execute_pipe;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic         AluSrc;
    logic [3:0]   AluControl;
    logic         MulOp;
    logic [N-1:0] PC_E;
    logic [N-1:0] signImm_E;
    logic [N-1:0] readData1_E;
    logic [N-1:0] readData2_E;
    logic         out_valid;
    logic [N-1:0] aluResult_M;
    logic [N-1:0] writeData_M;
    logic [N-1:0] PCBranch_M;
    logic         zero_M;

    int total = 0;
    int bad   = 0;

    execute_pipe #(.N(N), .MUL_EN(1'b1)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .AluSrc      (AluSrc),
        .AluControl  (AluControl),
        .MulOp       (MulOp),
        .PC_E        (PC_E),
        .signImm_E   (signImm_E),
        .readData1_E (readData1_E),
        .readData2_E (readData2_E),
        .out_valid   (out_valid),
        .aluResult_M (aluResult_M),
        .writeData_M (writeData_M),
        .PCBranch_M  (PCBranch_M),
        .zero_M      (zero_M)
    );

    // clock / reset block
    always #5 clk = ~clk;

    function automatic logic [N-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Reference ALU from the function table.
    function automatic logic [N-1:0] ref_alu(input logic [3:0] code, input logic [N-1:0] a,
                                             input logic [N-1:0] b);
        case (code)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return b;
            4'b1100: return ~(a | b);
            default: return '0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic v, input logic [3:0] ctrl, input logic src, input logic mul,
                          input logic [N-1:0] pc, input logic [N-1:0] imm,
                          input logic [N-1:0] a, input logic [N-1:0] b);
        in_valid    = v;
        AluControl  = ctrl;
        AluSrc      = src;
        MulOp       = mul;
        PC_E        = pc;
        signImm_E   = imm;
        readData1_E = a;
        readData2_E = b;
    endtask

    // Driver: one ALU op, checked one edge after accept.
    task automatic do_alu(input string tag, input logic [3:0] ctrl, input logic src,
                          input logic [N-1:0] pc, input logic [N-1:0] imm,
                          input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] exp_r;
        exp_r = ref_alu(ctrl, a, src ? imm : b);
        @(negedge clk);
        set_op(1'b1, ctrl, src, 1'b0, pc, imm, a, b);
        check({tag, "_rdy"}, in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, "_vld"}, out_valid, 1);
        check({tag, "_res"}, aluResult_M, exp_r);
        check({tag, "_zero"}, zero_M, exp_r == 0);
        check({tag, "_wd"}, writeData_M, b);
        check({tag, "_pcb"}, PCBranch_M, pc + (imm << 2));
    endtask

    // Driver: one MUL op; junk ops are offered while busy and must be ignored.
    task automatic do_mul(input string tag, input logic src, input logic [N-1:0] pc,
                          input logic [N-1:0] imm, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] exp_r;
        int lat;
        bit rdy_low;
        exp_r = a * (src ? imm : b);
        @(negedge clk);
        set_op(1'b1, 4'b0010, src, 1'b1, pc, imm, a, b);
        @(posedge clk);
        #1;
        lat = 0;
        rdy_low = 1'b1;
        while (!out_valid && lat < N + 8) begin
            if (in_ready) rdy_low = 1'b0;
            set_op($urandom_range(0, 1), 4'b0010, $urandom_range(0, 1), $urandom_range(0, 1),
                   rnd64(), rnd64(), rnd64(), rnd64());
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        check({tag, "_lat"}, lat, N);
        check({tag, "_rdylow"}, rdy_low, 1);
        check({tag, "_vld"}, out_valid, 1);
        check({tag, "_res"}, aluResult_M, exp_r);
        check({tag, "_zero"}, zero_M, exp_r == 0);
        check({tag, "_wd"}, writeData_M, b);
        check({tag, "_pcb"}, PCBranch_M, pc + (imm << 2));
        check({tag, "_rdyback"}, in_ready, 1);
    endtask

    // Starts a MUL and returns just after its accept edge.
    task automatic start_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        set_op(1'b1, 4'b0010, 1'b0, 1'b1, 64'h0, 64'h0, a, b);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    logic [3:0] codes [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
                              4'b0111, 4'b1100, 4'b0011, 4'b1111};
    bit seen_valid;
    logic [N-1:0] held;

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        set_op(1'b0, 4'b0000, 1'b0, 1'b0, '0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld", out_valid, 0);
        check("rst_res", aluResult_M, 0);
        check("rst_wd", writeData_M, 0);
        check("rst_pcb", PCBranch_M, 0);
        check("rst_zero", zero_M, 0);
        check("rst_rdy", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;

        // ADD 5+7 then check the pulse ends and data holds
        do_alu("add", 4'b0010, 1'b0, 64'h40, 64'h1, 64'd5, 64'd7);
        @(posedge clk);
        #1;
        check("add_pulse", out_valid, 0);
        check("add_hold", aluResult_M, 64'd12);

        do_alu("sub_eq", 4'b0110, 1'b0, 64'h100, 64'd3, 64'h1234, 64'h1234);
        check("sub_pcb", PCBranch_M, 64'h10C);

        // back-to-back ALU ops
        do_alu("b2b0", 4'b0001, 1'b1, rnd64(), rnd64(), rnd64(), rnd64());
        do_alu("b2b1", 4'b1100, 1'b0, rnd64(), rnd64(), rnd64(), rnd64());

        do_mul("mul42", 1'b1, 64'h200, 64'd6, 64'd7, 64'd99);
        do_mul("mulwrap", 1'b0, 64'h0, 64'h0, 64'h1_0000_0000, 64'h1_0000_0000);

        // Flush at edge k+10 of a MUL, with an ADD offered the same cycle
        start_mul(64'd11, 64'd13);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        set_op(1'b1, 4'b0010, 1'b0, 1'b0, 64'h0, 64'h0, 64'd1, 64'd2);
        held = aluResult_M;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_vld", out_valid, 0);
        check("fl_rdy", in_ready, 1);
        check("fl_hold", aluResult_M, held);
        seen_valid = 1'b0;
        repeat (N + 2) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid = 1'b1;
        end
        check("fl_noresult", seen_valid, 0);
        do_alu("fl_next", 4'b0010, 1'b0, rnd64(), rnd64(), 64'd20, 64'd22);

        // Flush in IDLE drops an ALU op
        @(negedge clk);
        flush = 1'b1;
        set_op(1'b1, 4'b0000, 1'b0, 1'b0, 64'h0, 64'h0, 64'hFF, 64'h0F);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_idle_vld", out_valid, 0);
        check("fl_idle_hold", aluResult_M, 64'd42);

        // Asynchronous reset in the middle of a MUL
        start_mul(64'd1234, 64'd5678);
        repeat (20) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("rmid_vld", out_valid, 0);
        check("rmid_res", aluResult_M, 0);
        check("rmid_wd", writeData_M, 0);
        check("rmid_pcb", PCBranch_M, 0);
        check("rmid_rdy", in_ready, 1);
        #2;
        reset = 1'b0;
        do_mul("rmid_mul", 1'b0, rnd64(), rnd64(), rnd64(), rnd64());

        // Random ALU ops
        for (int i = 0; i < 30; i++) begin
            do_alu("rnd_alu", codes[$urandom_range(0, 7)], $urandom_range(0, 1),
                   rnd64(), rnd64(), rnd64(), ($urandom_range(0, 3) == 0) ? 64'h0 : rnd64());
        end

        // Random MUL ops, including small operands
        for (int i = 0; i < 4; i++) begin
            do_mul("rnd_mul", $urandom_range(0, 1), rnd64(), rnd64(), rnd64(),
                   (i == 0) ? 64'({$urandom_range(0, 255)}) : rnd64());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
